// File: rtl/operand_select_stage.sv
// Decode-to-execute operand select: forwarding resolution with hazard detection,
// fence.i / store-limit stall, and a valid/ready output register feeding EXE.
module operand_select_stage #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned NUM_FW     = 3,
    parameter int unsigned CTRL_W     = 64,
    parameter int unsigned MAX_STORES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [XLEN-1:0]          in_pc,
    input  logic [31:0]              in_inst,
    input  logic [3:0]               in_op1_sel,
    input  logic [3:0]               in_op2_sel,
    input  logic [XLEN-1:0]          in_imm_i,
    input  logic [XLEN-1:0]          in_imm_s,
    input  logic [XLEN-1:0]          in_imm_j,
    input  logic [XLEN-1:0]          in_imm_u,
    input  logic [XLEN-1:0]          in_imm_z,
    input  logic                     in_use_rs1,
    input  logic                     in_use_rs2,
    input  logic                     in_mem_wen,
    input  logic                     in_fence_i,
    input  logic [CTRL_W-1:0]        in_ctrl,
    output logic [4:0]               rf_rs1_addr,
    output logic [4:0]               rf_rs2_addr,
    input  logic [XLEN-1:0]          rf_rs1_data,
    input  logic [XLEN-1:0]          rf_rs2_data,
    input  logic [NUM_FW-1:0]        fw_valid,
    input  logic [NUM_FW-1:0]        fw_can_forward,
    input  logic [5*NUM_FW-1:0]      fw_addr,
    input  logic [XLEN*NUM_FW-1:0]   fw_wdata,
    input  logic                     store_done,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_pc,
    output logic [31:0]              out_inst,
    output logic [CTRL_W-1:0]        out_ctrl,
    output logic                     out_mem_wen,
    output logic [XLEN-1:0]          out_op1_data,
    output logic [XLEN-1:0]          out_op2_data,
    output logic [XLEN-1:0]          out_rs2_data,
    output logic                     dh_stall,
    output logic                     fence_stall,
    output logic [31:0]              stall_cycles
);

    localparam int unsigned CNT_W = $clog2(MAX_STORES + 1);

    localparam logic [3:0] OP1_RS1  = 4'd1;
    localparam logic [3:0] OP1_PC   = 4'd2;
    localparam logic [3:0] OP1_IMZ  = 4'd3;
    localparam logic [3:0] OP2_RS2W = 4'd1;
    localparam logic [3:0] OP2_IMI  = 4'd2;
    localparam logic [3:0] OP2_IMS  = 4'd3;
    localparam logic [3:0] OP2_IMJ  = 4'd4;
    localparam logic [3:0] OP2_IMU  = 4'd5;

    logic [4:0]        w_rs1;
    logic [4:0]        w_rs2;
    logic [XLEN-1:0]   w_rs1_data;
    logic [XLEN-1:0]   w_rs2_data;
    logic              w_hit1;
    logic              w_hit2;
    logic              w_haz1;
    logic              w_haz2;
    logic [XLEN-1:0]   w_op1;
    logic [XLEN-1:0]   w_op2;
    logic              w_accept;
    logic              w_out_hs;
    logic              w_cnt_inc;
    logic              w_cnt_dec;
    logic              w_cnt_full;

    logic              r_out_valid;
    logic [XLEN-1:0]   r_pc;
    logic [31:0]       r_inst;
    logic [CTRL_W-1:0] r_ctrl;
    logic              r_mem_wen;
    logic [XLEN-1:0]   r_op1;
    logic [XLEN-1:0]   r_op2;
    logic [XLEN-1:0]   r_rs2;
    logic [CNT_W-1:0]  r_cnt;
    logic [31:0]       r_stall_cycles;

    assign w_rs1       = in_inst[19:15];
    assign w_rs2       = in_inst[24:20];
    assign rf_rs1_addr = w_rs1;
    assign rf_rs2_addr = w_rs2;

    // Youngest matching source wins; x0 is hard-wired to zero and never hazarded.
    always_comb begin
        w_rs1_data = rf_rs1_data;
        w_rs2_data = rf_rs2_data;
        w_hit1     = 1'b0;
        w_hit2     = 1'b0;
        w_haz1     = 1'b0;
        w_haz2     = 1'b0;
        for (int i = 0; i < NUM_FW; i++) begin
            if (!w_hit1 && fw_valid[i] && (fw_addr[i*5 +: 5] == w_rs1)) begin
                w_hit1     = 1'b1;
                w_haz1     = !fw_can_forward[i];
                w_rs1_data = fw_wdata[i*XLEN +: XLEN];
            end
            if (!w_hit2 && fw_valid[i] && (fw_addr[i*5 +: 5] == w_rs2)) begin
                w_hit2     = 1'b1;
                w_haz2     = !fw_can_forward[i];
                w_rs2_data = fw_wdata[i*XLEN +: XLEN];
            end
        end
        if (w_rs1 == 5'd0) begin
            w_rs1_data = '0;
            w_haz1     = 1'b0;
        end
        if (w_rs2 == 5'd0) begin
            w_rs2_data = '0;
            w_haz2     = 1'b0;
        end
    end

    always_comb begin
        w_op1 = '0;
        case (in_op1_sel)
            OP1_RS1: w_op1 = w_rs1_data;
            OP1_PC:  w_op1 = in_pc;
            OP1_IMZ: w_op1 = in_imm_z;
            default: w_op1 = '0;
        endcase
    end

    always_comb begin
        w_op2 = '0;
        case (in_op2_sel)
            OP2_RS2W: w_op2 = w_rs2_data;
            OP2_IMI:  w_op2 = in_imm_i;
            OP2_IMS:  w_op2 = in_imm_s;
            OP2_IMJ:  w_op2 = in_imm_j;
            OP2_IMU:  w_op2 = in_imm_u;
            default:  w_op2 = '0;
        endcase
    end

    assign w_cnt_full  = (r_cnt == CNT_W'(MAX_STORES));
    assign dh_stall    = in_valid & ((in_use_rs1 & w_haz1) | (in_use_rs2 & w_haz2));
    // A store still sitting in the output register counts as outstanding for fence.i.
    assign fence_stall = in_valid & ((in_fence_i & ((r_cnt != '0) | (r_out_valid & r_mem_wen)))
                                   | (in_mem_wen & w_cnt_full));

    assign in_ready  = !r_out_valid | out_ready;
    assign w_accept  = in_valid & in_ready & !dh_stall & !fence_stall & !flush;
    assign w_out_hs  = r_out_valid & out_ready;
    assign w_cnt_inc = w_out_hs & r_mem_wen;
    assign w_cnt_dec = store_done & (r_cnt != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_pc        <= '0;
            r_inst      <= '0;
            r_ctrl      <= '0;
            r_mem_wen   <= 1'b0;
            r_op1       <= '0;
            r_op2       <= '0;
            r_rs2       <= '0;
        end else begin
            if (flush) begin
                r_out_valid <= 1'b0;
            end else if (w_accept) begin
                r_out_valid <= 1'b1;
            end else if (w_out_hs) begin
                r_out_valid <= 1'b0;
            end
            if (w_accept) begin
                r_pc      <= in_pc;
                r_inst    <= in_inst;
                r_ctrl    <= in_ctrl;
                r_mem_wen <= in_mem_wen;
                r_op1     <= w_op1;
                r_op2     <= w_op2;
                r_rs2     <= w_rs2_data;
            end
        end
    end

    // Outstanding-store counter; clamps at MAX_STORES as a safety net.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_cnt_inc && !w_cnt_dec && !w_cnt_full) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else if (w_cnt_dec && !w_cnt_inc) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles <= '0;
        end else if ((dh_stall | fence_stall) && (r_stall_cycles != 32'hFFFF_FFFF)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign out_valid    = r_out_valid;
    assign out_pc       = r_pc;
    assign out_inst     = r_inst;
    assign out_ctrl     = r_ctrl;
    assign out_mem_wen  = r_mem_wen;
    assign out_op1_data = r_op1;
    assign out_op2_data = r_op2;
    assign out_rs2_data = r_rs2;
    assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_operand_select_stage.sv
// Directed bench for operand_select_stage: forwarding, hazards, store/fence stalls,
// back-pressure, flush and asynchronous reset.
module tb_operand_select_stage;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned NUM_FW = 3;
    localparam int unsigned CTRL_W = 64;

    localparam logic [3:0] OP1_RS1  = 4'd1;
    localparam logic [3:0] OP1_PC   = 4'd2;
    localparam logic [3:0] OP1_IMZ  = 4'd3;
    localparam logic [3:0] OP2_RS2W = 4'd1;
    localparam logic [3:0] OP2_IMI  = 4'd2;
    localparam logic [3:0] OP2_IMS  = 4'd3;
    localparam logic [3:0] OP2_IMJ  = 4'd4;
    localparam logic [3:0] OP2_IMU  = 4'd5;

    localparam logic [31:0] FENCE_I = 32'h0000_100F;

    logic                   clk;
    logic                   rst_n;
    logic                   flush;
    logic                   in_valid;
    logic                   in_ready;
    logic [XLEN-1:0]        in_pc;
    logic [31:0]            in_inst;
    logic [3:0]             in_op1_sel;
    logic [3:0]             in_op2_sel;
    logic [XLEN-1:0]        in_imm_i;
    logic [XLEN-1:0]        in_imm_s;
    logic [XLEN-1:0]        in_imm_j;
    logic [XLEN-1:0]        in_imm_u;
    logic [XLEN-1:0]        in_imm_z;
    logic                   in_use_rs1;
    logic                   in_use_rs2;
    logic                   in_mem_wen;
    logic                   in_fence_i;
    logic [CTRL_W-1:0]      in_ctrl;
    logic [4:0]             rf_rs1_addr;
    logic [4:0]             rf_rs2_addr;
    logic [XLEN-1:0]        rf_rs1_data;
    logic [XLEN-1:0]        rf_rs2_data;
    logic [NUM_FW-1:0]      fw_valid;
    logic [NUM_FW-1:0]      fw_can_forward;
    logic [5*NUM_FW-1:0]    fw_addr;
    logic [XLEN*NUM_FW-1:0] fw_wdata;
    logic                   store_done;
    logic                   out_valid;
    logic                   out_ready;
    logic [XLEN-1:0]        out_pc;
    logic [31:0]            out_inst;
    logic [CTRL_W-1:0]      out_ctrl;
    logic                   out_mem_wen;
    logic [XLEN-1:0]        out_op1_data;
    logic [XLEN-1:0]        out_op2_data;
    logic [XLEN-1:0]        out_rs2_data;
    logic                   dh_stall;
    logic                   fence_stall;
    logic [31:0]            stall_cycles;

    int checks = 0;
    int errors = 0;

    operand_select_stage #(
        .XLEN(XLEN), .NUM_FW(NUM_FW), .CTRL_W(CTRL_W), .MAX_STORES(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
        .in_op1_sel(in_op1_sel), .in_op2_sel(in_op2_sel),
        .in_imm_i(in_imm_i), .in_imm_s(in_imm_s), .in_imm_j(in_imm_j),
        .in_imm_u(in_imm_u), .in_imm_z(in_imm_z),
        .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2),
        .in_mem_wen(in_mem_wen), .in_fence_i(in_fence_i), .in_ctrl(in_ctrl),
        .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
        .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
        .fw_valid(fw_valid), .fw_can_forward(fw_can_forward),
        .fw_addr(fw_addr), .fw_wdata(fw_wdata), .store_done(store_done),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_inst(out_inst), .out_ctrl(out_ctrl), .out_mem_wen(out_mem_wen),
        .out_op1_data(out_op1_data), .out_op2_data(out_op2_data),
        .out_rs2_data(out_rs2_data), .dh_stall(dh_stall),
        .fence_stall(fence_stall), .stall_cycles(stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    function automatic logic [31:0] mk_inst(input logic [4:0] rs2, input logic [4:0] rs1);
        return {7'd0, rs2, rs1, 3'd0, 5'd3, 7'h33};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle;
        flush          = 1'b0;
        in_valid       = 1'b0;
        in_pc          = '0;
        in_inst        = '0;
        in_op1_sel     = '0;
        in_op2_sel     = '0;
        in_imm_i       = 32'h111;
        in_imm_s       = 32'h222;
        in_imm_j       = 32'h333;
        in_imm_u       = 32'h444;
        in_imm_z       = 32'h555;
        in_use_rs1     = 1'b0;
        in_use_rs2     = 1'b0;
        in_mem_wen     = 1'b0;
        in_fence_i     = 1'b0;
        in_ctrl        = '0;
        rf_rs1_data    = '0;
        rf_rs2_data    = '0;
        fw_valid       = '0;
        fw_can_forward = '0;
        fw_addr        = '0;
        fw_wdata       = '0;
        store_done     = 1'b0;
        out_ready      = 1'b1;
    endtask

    task automatic do_reset;
        set_idle();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset;
        set_idle();
        rst_n = 1'b0;
        #3;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL reset_stall_cycles: got %0d expected 0", stall_cycles); end
        checks++; if (out_op1_data !== 32'd0) begin errors++; $display("FAIL reset_op1: got %h expected 0", out_op1_data); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_add;
        do_reset();
        in_inst     = mk_inst(5'd2, 5'd1);
        rf_rs1_data = 32'd5;
        rf_rs2_data = 32'd7;
        in_op1_sel  = OP1_RS1;
        in_op2_sel  = OP2_RS2W;
        in_use_rs1  = 1'b1;
        in_use_rs2  = 1'b1;
        in_pc       = 32'h100;
        in_ctrl     = 64'hDEAD_BEEF_0123_4567;
        in_valid    = 1'b1;
        #1;
        checks++; if (rf_rs1_addr !== 5'd1) begin errors++; $display("FAIL add_rs1_addr: got %0d expected 1", rf_rs1_addr); end
        checks++; if (rf_rs2_addr !== 5'd2) begin errors++; $display("FAIL add_rs2_addr: got %0d expected 2", rf_rs2_addr); end
        checks++; if (dh_stall !== 1'b0) begin errors++; $display("FAIL add_dh_stall: got %b expected 0", dh_stall); end
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_out_valid: got %b expected 1", out_valid); end
        checks++; if (out_op1_data !== 32'd5) begin errors++; $display("FAIL add_op1: got %h expected 5", out_op1_data); end
        checks++; if (out_op2_data !== 32'd7) begin errors++; $display("FAIL add_op2: got %h expected 7", out_op2_data); end
        checks++; if (out_pc !== 32'h100) begin errors++; $display("FAIL add_pc: got %h expected 100", out_pc); end
        checks++; if (out_ctrl !== 64'hDEAD_BEEF_0123_4567) begin errors++; $display("FAIL add_ctrl: got %h expected deadbeef01234567", out_ctrl); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_forward;
        do_reset();
        in_inst        = mk_inst(5'd2, 5'd1);
        rf_rs1_data    = 32'd5;
        rf_rs2_data    = 32'd7;
        fw_valid       = 3'b111;
        fw_addr        = {5'd1, 5'd2, 5'd1};
        fw_can_forward = 3'b111;
        fw_wdata       = {32'hBB, 32'hCC, 32'hAA};
        in_op1_sel     = OP1_RS1;
        in_op2_sel     = OP2_RS2W;
        in_use_rs1     = 1'b1;
        in_use_rs2     = 1'b1;
        in_valid       = 1'b1;
        tick();
        checks++; if (out_op1_data !== 32'hAA) begin errors++; $display("FAIL fw_youngest_op1: got %h expected aa", out_op1_data); end
        checks++; if (out_op2_data !== 32'hCC) begin errors++; $display("FAIL fw_src1_op2: got %h expected cc", out_op2_data); end
        fw_can_forward = 3'b110;
        #1;
        checks++; if (dh_stall !== 1'b1) begin errors++; $display("FAIL fw_hazard: got %b expected 1", dh_stall); end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (stall_cycles !== 32'(k + 1)) begin errors++; $display("FAIL fw_stall_count: got %0d expected %0d", stall_cycles, k + 1); end
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fw_no_accept: got %b expected 0", out_valid); end
        end
        fw_can_forward = 3'b111;
        #1;
        checks++; if (dh_stall !== 1'b0) begin errors++; $display("FAIL fw_hazard_clear: got %b expected 0", dh_stall); end
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fw_accept_after: got %b expected 1", out_valid); end
        checks++; if (out_op1_data !== 32'hAA) begin errors++; $display("FAIL fw_op1_after: got %h expected aa", out_op1_data); end
        checks++; if (stall_cycles !== 32'd3) begin errors++; $display("FAIL fw_stall_final: got %0d expected 3", stall_cycles); end
    endtask

    task automatic test_x0_unused;
        do_reset();
        in_inst        = mk_inst(5'd2, 5'd0);
        rf_rs1_data    = 32'h99;
        fw_valid       = 3'b011;
        fw_addr        = {5'd0, 5'd2, 5'd0};
        fw_can_forward = 3'b000;
        fw_wdata       = {32'h0, 32'h77, 32'h66};
        in_op1_sel     = OP1_RS1;
        in_op2_sel     = OP2_IMI;
        in_use_rs1     = 1'b1;
        in_use_rs2     = 1'b0;
        in_valid       = 1'b1;
        #1;
        checks++; if (dh_stall !== 1'b0) begin errors++; $display("FAIL x0_no_stall: got %b expected 0", dh_stall); end
        tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL x0_accept: got %b expected 1", out_valid); end
        checks++; if (out_op1_data !== 32'd0) begin errors++; $display("FAIL x0_op1_zero: got %h expected 0", out_op1_data); end
        checks++; if (out_op2_data !== 32'h111) begin errors++; $display("FAIL x0_op2_imi: got %h expected 111", out_op2_data); end
        checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL x0_stall_count: got %0d expected 0", stall_cycles); end
        in_use_rs2 = 1'b1;
        #1;
        checks++; if (dh_stall !== 1'b1) begin errors++; $display("FAIL rs2_used_hazard: got %b expected 1", dh_stall); end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_op_select;
        logic [3:0]  s1 [6] = '{OP1_RS1, OP1_PC, OP1_IMZ, 4'd0, 4'hF, OP1_RS1};
        logic [3:0]  s2 [6] = '{OP2_RS2W, OP2_IMI, OP2_IMS, OP2_IMJ, OP2_IMU, 4'd9};
        logic [31:0] e1 [6] = '{32'hA, 32'h1000, 32'h555, 32'h0, 32'h0, 32'hA};
        logic [31:0] e2 [6] = '{32'hB, 32'h111, 32'h222, 32'h333, 32'h444, 32'h0};
        do_reset();
        in_inst     = mk_inst(5'd2, 5'd1);
        rf_rs1_data = 32'hA;
        rf_rs2_data = 32'hB;
        in_pc       = 32'h1000;
        in_use_rs1  = 1'b1;
        in_use_rs2  = 1'b1;
        in_valid    = 1'b1;
        for (int k = 0; k < 6; k++) begin
            in_op1_sel = s1[k];
            in_op2_sel = s2[k];
            tick();
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sel%0d_valid: got %b expected 1", k, out_valid); end
            checks++; if (out_op1_data !== e1[k]) begin errors++; $display("FAIL sel%0d_op1: got %h expected %h", k, out_op1_data, e1[k]); end
            checks++; if (out_op2_data !== e2[k]) begin errors++; $display("FAIL sel%0d_op2: got %h expected %h", k, out_op2_data, e2[k]); end
            checks++; if (out_rs2_data !== 32'hB) begin errors++; $display("FAIL sel%0d_rs2: got %h expected b", k, out_rs2_data); end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_store_limit;
        do_reset();
        in_mem_wen = 1'b1;
        in_valid   = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        checks++; if (out_mem_wen !== 1'b1) begin errors++; $display("FAIL st_out_mem_wen: got %b expected 1", out_mem_wen); end
        in_valid = 1'b0;
        tick();
        in_valid = 1'b1;
        #1;
        checks++; if (fence_stall !== 1'b1) begin errors++; $display("FAIL st_fifth_stall: got %b expected 1", fence_stall); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL st_fifth_blocked: got %b expected 0", out_valid); end
        checks++; if (stall_cycles !== 32'd1) begin errors++; $display("FAIL st_stall_count1: got %0d expected 1", stall_cycles); end
        store_done = 1'b1;
        tick();
        store_done = 1'b0;
        #1;
        checks++; if (fence_stall !== 1'b0) begin errors++; $display("FAIL st_after_done: got %b expected 0", fence_stall); end
        tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL st_fifth_accept: got %b expected 1", out_valid); end
        in_valid   = 1'b0;
        store_done = 1'b1;
        tick();
        store_done = 1'b0;
        in_valid   = 1'b1;
        #1;
        checks++; if (fence_stall !== 1'b0) begin errors++; $display("FAIL st_simul_not_full: got %b expected 0", fence_stall); end
        tick();
        in_valid = 1'b0;
        tick();
        in_valid = 1'b1;
        #1;
        checks++; if (fence_stall !== 1'b1) begin errors++; $display("FAIL st_simul_refill: got %b expected 1", fence_stall); end
        in_mem_wen = 1'b0;
        in_fence_i = 1'b1;
        #1;
        checks++; if (fence_stall !== 1'b1) begin errors++; $display("FAIL st_fence_pending: got %b expected 1", fence_stall); end
        checks++; if (stall_cycles !== 32'd2) begin errors++; $display("FAIL st_stall_count2: got %0d expected 2", stall_cycles); end
        in_valid   = 1'b0;
        in_fence_i = 1'b0;
    endtask

    task automatic test_fence_i;
        do_reset();
        in_mem_wen = 1'b1;
        in_valid   = 1'b1;
        tick();
        in_mem_wen = 1'b0;
        in_fence_i = 1'b1;
        in_inst    = FENCE_I;
        #1;
        checks++; if (fence_stall !== 1'b1) begin errors++; $display("FAIL fi_store_in_outreg: got %b expected 1", fence_stall); end
        tick();
        checks++; if (fence_stall !== 1'b1) begin errors++; $display("FAIL fi_cnt_pending: got %b expected 1", fence_stall); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fi_blocked: got %b expected 0", out_valid); end
        tick();
        store_done = 1'b1;
        tick();
        store_done = 1'b0;
        #1;
        checks++; if (fence_stall !== 1'b0) begin errors++; $display("FAIL fi_released: got %b expected 0", fence_stall); end
        tick();
        in_valid   = 1'b0;
        in_fence_i = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fi_accepted: got %b expected 1", out_valid); end
        checks++; if (out_inst !== FENCE_I) begin errors++; $display("FAIL fi_inst: got %h expected %h", out_inst, FENCE_I); end
        checks++; if (stall_cycles !== 32'd3) begin errors++; $display("FAIL fi_stall_count: got %0d expected 3", stall_cycles); end
        tick();
    endtask

    task automatic test_hold_flush;
        do_reset();
        out_ready = 1'b0;
        in_pc     = 32'h40;
        in_inst   = mk_inst(5'd4, 5'd3);
        in_valid  = 1'b1;
        tick();
        in_pc   = 32'h44;
        in_inst = mk_inst(5'd6, 5'd5);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready: got %b expected 0", in_ready); end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hold%0d_valid: got %b expected 1", k, out_valid); end
            checks++; if (out_pc !== 32'h40) begin errors++; $display("FAIL hold%0d_pc: got %h expected 40", k, out_pc); end
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b expected 0", out_valid); end
        tick();
        in_valid = 1'b0;
        checks++; if (out_pc !== 32'h44) begin errors++; $display("FAIL flush_next_pc: got %h expected 44", out_pc); end
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_stall;
        do_reset();
        in_pc      = 32'h80;
        in_mem_wen = 1'b1;
        in_valid   = 1'b1;
        tick();
        tick();
        out_ready  = 1'b0;
        in_mem_wen = 1'b0;
        in_fence_i = 1'b1;
        in_inst    = FENCE_I;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b expected 0", out_valid); end
        checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL rst_mid_stall_count: got %0d expected 0", stall_cycles); end
        checks++; if (out_pc !== 32'd0) begin errors++; $display("FAIL rst_mid_pc: got %h expected 0", out_pc); end
        #1;
        rst_n = 1'b1;
        #1;
        checks++; if (fence_stall !== 1'b0) begin errors++; $display("FAIL rst_mid_cnt_clear: got %b expected 0", fence_stall); end
        in_valid   = 1'b0;
        in_fence_i = 1'b0;
        out_ready  = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_add();
        test_forward();
        test_x0_unused();
        test_op_select();
        test_store_limit();
        test_fence_i();
        test_hold_flush();
        test_reset_mid_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
